// File: rtl/ebike_pkg.sv
// Shared constants and types for the e-bike commutation block: phase select
// encodings, rotor-state type and default duty-path tuning values.
package ebike_pkg;

    localparam logic [1:0] SEL_OFF = 2'b00;
    localparam logic [1:0] SEL_REV = 2'b01;
    localparam logic [1:0] SEL_FWD = 2'b10;
    localparam logic [1:0] SEL_BRK = 2'b11;

    typedef logic [2:0] rot_state_t;

    localparam logic [10:0] DFLT_BRAKE_DUTY = 11'h600;
    localparam logic [10:0] DFLT_SLEW       = 11'd8;

endpackage

// File: rtl/commutator_ctrl_if.sv
// Bus between the commutation controller and its surroundings: hall inputs,
// brake/drive commands and PWM sync in; phase selects, duty and fault out.
interface commutator_ctrl_if;

    logic        hallGrn;
    logic        hallYlw;
    logic        hallBlu;
    logic        brake_n;
    logic [10:0] drv_mag;
    logic        PWM_synch;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic [10:0] duty;
    logic        hall_fault;

    modport slave (
        input  hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
        output selGrn, selYlw, selBlu, duty, hall_fault
    );

    modport master (
        output hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
        input  selGrn, selYlw, selBlu, duty, hall_fault
    );

endinterface

// File: rtl/commutator_ctrl_hall_sync.sv
// Two-flop synchronizer for the three asynchronous hall sensor lines.
module hall_sync
    import ebike_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  rot_state_t hall_raw,
    output rot_state_t hall_s
);

    rot_state_t meta_q, meta_d;
    rot_state_t sync_q, sync_d;

    always_comb begin
        meta_d = hall_raw;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign hall_s = sync_q;

endmodule

// File: rtl/commutator_ctrl.sv
// Brushless commutation and duty sequencer: decodes hall position into phase
// selects and slews drive duty, with regen braking and hall fault shutdown.
module commutator_ctrl
    import ebike_pkg::*;
#(
    parameter logic [10:0] SLEW       = DFLT_SLEW,
    parameter logic [10:0] BRAKE_DUTY = DFLT_BRAKE_DUTY,
    parameter int          FAULT_CNT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    commutator_ctrl_if.slave  bus
);

    localparam logic [1:0] FAULT_LIM = FAULT_CNT[1:0];

    rot_state_t  hall_s;
    rot_state_t  rot_state_q, rot_state_d;
    logic        brake_q, brake_d;
    logic [10:0] duty_q, duty_d;
    logic [1:0]  fault_cnt_q, fault_cnt_d;
    logic        hall_fault_q, hall_fault_d;
    logic [5:0]  sel;

    // One PWM-period slew step toward the target, computed in 12 bits so the
    // upward add can exceed 11'h7FF without wrapping before the clamp.
    function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic [10:0] tgt);
        logic [11:0] up;
        logic [11:0] dn;
        up = {1'b0, cur} + {1'b0, SLEW};
        dn = (cur >= SLEW) ? ({1'b0, cur} - {1'b0, SLEW}) : 12'd0;
        if (cur < tgt)
            slew_step = (up > {1'b0, tgt}) ? tgt : up[10:0];
        else if (cur > tgt)
            slew_step = (dn < {1'b0, tgt}) ? tgt : dn[10:0];
        else
            slew_step = cur;
    endfunction

    function automatic logic hall_invalid(input rot_state_t h);
        hall_invalid = (h == 3'b000) || (h == 3'b111);
    endfunction

    hall_sync u_hall_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall_raw ({bus.hallGrn, bus.hallYlw, bus.hallBlu}),
        .hall_s   (hall_s)
    );

    always_comb begin
        rot_state_d  = rot_state_q;
        brake_d      = brake_q;
        duty_d       = duty_q;
        fault_cnt_d  = fault_cnt_q;
        hall_fault_d = hall_fault_q;
        if (bus.PWM_synch) begin
            rot_state_d = hall_s;
            brake_d     = ~bus.brake_n;
            if (hall_invalid(hall_s))
                fault_cnt_d = (fault_cnt_q == 2'd3) ? 2'd3 : fault_cnt_q + 2'd1;
            else
                fault_cnt_d = 2'd0;
            if (fault_cnt_d >= FAULT_LIM)
                hall_fault_d = 1'b1;
            // First unbraked sample after a brake drops duty to 0 so the ramp restarts cleanly.
            if (hall_fault_d)
                duty_d = '0;
            else if (brake_d)
                duty_d = BRAKE_DUTY;
            else if (brake_q)
                duty_d = '0;
            else
                duty_d = slew_step(duty_q, bus.drv_mag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_state_q  <= '0;
            brake_q      <= 1'b0;
            duty_q       <= '0;
            fault_cnt_q  <= '0;
            hall_fault_q <= 1'b0;
        end else begin
            rot_state_q  <= rot_state_d;
            brake_q      <= brake_d;
            duty_q       <= duty_d;
            fault_cnt_q  <= fault_cnt_d;
            hall_fault_q <= hall_fault_d;
        end
    end

    always_comb begin
        sel = {SEL_OFF, SEL_OFF, SEL_OFF};
        if (hall_fault_q)
            sel = {SEL_OFF, SEL_OFF, SEL_OFF};
        else if (brake_q)
            sel = {SEL_BRK, SEL_BRK, SEL_BRK};
        else begin
            case (rot_state_q)
                3'b101:  sel = {SEL_FWD, SEL_REV, SEL_OFF};
                3'b100:  sel = {SEL_FWD, SEL_OFF, SEL_REV};
                3'b110:  sel = {SEL_OFF, SEL_FWD, SEL_REV};
                3'b010:  sel = {SEL_REV, SEL_FWD, SEL_OFF};
                3'b011:  sel = {SEL_REV, SEL_OFF, SEL_FWD};
                3'b001:  sel = {SEL_OFF, SEL_REV, SEL_FWD};
                default: sel = {SEL_OFF, SEL_OFF, SEL_OFF};
            endcase
        end
    end

    assign bus.selGrn     = sel[5:4];
    assign bus.selYlw     = sel[3:2];
    assign bus.selBlu     = sel[1:0];
    assign bus.duty       = duty_q;
    assign bus.hall_fault = hall_fault_q;

endmodule
